// File: rtl/lift_pkg.sv
// Shared definitions for the forward and inverse integer lifting blocks:
// FSM state encoding, lifting shift amounts and default widths.
package lift_pkg;

    localparam int DEF_DW      = 8;
    localparam int DEF_BLK_PIX = 64;

    // Shift applied to the high band when predicting the even sample, and to
    // the even sample when updating the odd one.
    localparam int SH_H = 2;
    localparam int SH_E = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2
    } lift_state_e;

endpackage

// File: rtl/inv_lift_core.sv
// Inverse lifting arithmetic: rebuilds an even/odd pixel pair from one
// low-band and one high-band coefficient, modulo 2^DW with logical shifts.
module inv_lift_core
    import lift_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic [DW-1:0] L,
    input  logic [DW-1:0] H,
    output logic [DW-1:0] even,
    output logic [DW-1:0] odd
);

    // Odd depends on the freshly reconstructed even, so the two are chained.
    assign even = L - (H >> SH_H);
    assign odd  = H + (even >> SH_E);

endmodule

// File: rtl/inv_lift_decoder.sv
// Inverse lifting decoder: accepts (L,H) coefficient pairs and emits two
// pixels per pair. Optional block-end marker out_last under INV_LIFT_LAST_EN.
module inv_lift_decoder
    import lift_pkg::*;
#(
    parameter int DW      = DEF_DW,
    parameter int BLK_PIX = DEF_BLK_PIX
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_L,
    input  logic [DW-1:0] in_H,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_pix
`ifdef INV_LIFT_LAST_EN
    ,
    output logic          out_last
`endif
);

    lift_state_e   state_q;
    lift_state_e   state_d;
    logic [DW-1:0] even_q;
    logic [DW-1:0] odd_q;
    logic [DW-1:0] core_even;
    logic [DW-1:0] core_odd;
    logic          accept;
    logic          out_hs;

    inv_lift_core #(.DW(DW)) u_core (
        .L    (in_L),
        .H    (in_H),
        .even (core_even),
        .odd  (core_odd)
    );

    // Ready only depends on state, out_ready and reset, never on in_valid.
    assign in_ready  = rst_n & ((state_q == IDLE) | ((state_q == ODD) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q != IDLE);
    assign out_hs    = out_valid & out_ready;
    assign out_pix   = (state_q == ODD) ? odd_q : even_q;

    always_comb begin
        // NOTE: next state defaults to the current one so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = EVEN;
            EVEN: if (out_hs) state_d = ODD;
            ODD:  if (out_hs) state_d = accept ? EVEN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state_q <= IDLE;
            even_q  <= '0;
            odd_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                even_q <= core_even;
                odd_q  <= core_odd;
            end
        end
    end

`ifdef INV_LIFT_LAST_EN
    localparam int CW = $clog2(BLK_PIX);

    logic [CW-1:0] cnt_q;

    // BLK_PIX is a power of two, so the counter wraps to 0 on its own.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (out_hs) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign out_last = out_valid & (cnt_q == CW'(BLK_PIX - 1));
`endif

endmodule

// File: tb/tb_inv_lift_decoder.sv
// Directed self-checking bench for inv_lift_decoder (DW=8, BLK_PIX=64);
// out_last checks are active when INV_LIFT_LAST_EN is defined.
module tb_inv_lift_decoder;

    localparam int DW      = 8;
    localparam int BLK_PIX = 64;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_L;
    logic [DW-1:0] in_H;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_pix;
`ifdef INV_LIFT_LAST_EN
    logic          out_last;
`endif

    int checks;
    int errors;

    inv_lift_decoder #(.DW(DW), .BLK_PIX(BLK_PIX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_L      (in_L),
        .in_H      (in_H),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pix   (out_pix)
`ifdef INV_LIFT_LAST_EN
        ,
        .out_last  (out_last)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_L = 8'd205; in_H = 8'd240; out_ready = 1'b1;
        tick(); tick();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %b want 1", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid got %b want 0", out_valid); end
`ifdef INV_LIFT_LAST_EN
        checks++;
        if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
`endif
    endtask

    task automatic test_single();
        out_ready = 1'b1; in_valid = 1'b1; in_L = 8'd205; in_H = 8'd240;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL single_accept_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_pix !== 8'd145)
            begin errors++; $display("FAIL single_even got v=%b pix=%0d want v=1 pix=145", out_valid, out_pix); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL single_even_ready got %b want 0", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pix !== 8'd56)
            begin errors++; $display("FAIL single_odd got v=%b pix=%0d want v=1 pix=56", out_valid, out_pix); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL single_done got v=%b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1; in_valid = 1'b1; in_L = 8'd205; in_H = 8'd240;
        tick();
        in_L = 8'd65; in_H = 8'd65;
        #1;
        checks++;
        if (out_pix !== 8'd145 || in_ready !== 1'b0)
            begin errors++; $display("FAIL b2b_p0 got pix=%0d rdy=%b want pix=145 rdy=0", out_pix, in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pix !== 8'd56 || in_ready !== 1'b1)
            begin errors++; $display("FAIL b2b_p1 got v=%b pix=%0d rdy=%b want v=1 pix=56 rdy=1", out_valid, out_pix, in_ready); end
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_pix !== 8'd49)
            begin errors++; $display("FAIL b2b_p2 got v=%b pix=%0d want v=1 pix=49", out_valid, out_pix); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pix !== 8'd89 || in_ready !== 1'b1)
            begin errors++; $display("FAIL b2b_p3 got v=%b pix=%0d rdy=%b want v=1 pix=89 rdy=1", out_valid, out_pix, in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_done got v=%b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1; in_valid = 1'b1; in_L = 8'd205; in_H = 8'd240;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_pix !== 8'd145 || in_ready !== 1'b0)
                begin errors++; $display("FAIL bp_hold%0d got v=%b pix=%0d rdy=%b want v=1 pix=145 rdy=0", i, out_valid, out_pix, in_ready); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_pix !== 8'd145)
            begin errors++; $display("FAIL bp_even got v=%b pix=%0d want v=1 pix=145", out_valid, out_pix); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pix !== 8'd56)
            begin errors++; $display("FAIL bp_odd got v=%b pix=%0d want v=1 pix=56", out_valid, out_pix); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_done got v=%b want 0", out_valid); end
    endtask

    task automatic test_reset_in_odd();
        out_ready = 1'b1; in_valid = 1'b1; in_L = 8'd205; in_H = 8'd240;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pix !== 8'd56)
            begin errors++; $display("FAIL rst_odd_pre got v=%b pix=%0d want v=1 pix=56", out_valid, out_pix); end
        out_ready = 1'b0; rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_odd_ready got %b want 0", in_ready); end
        tick();
        rst_n = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_odd_valid got %b want 0", out_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_odd_leak%0d got v=%b pix=%0d want v=0", i, out_valid, out_pix); end
        end
    endtask

    // Runs straight after test_reset_in_odd, so out_last at pixel 63 also
    // shows the pixel counter restarted at 0.
    task automatic test_round_trip();
        logic [DW-1:0] pix [BLK_PIX];
        logic [DW-1:0] ls  [BLK_PIX/2];
        logic [DW-1:0] hs  [BLK_PIX/2];
        logic [DW-1:0] e, o, h;
        int idx, np, cyc;
        for (int i = 0; i < BLK_PIX; i++) pix[i] = DW'((i * 37 + 11) ^ (i << 3));
        for (int k = 0; k < BLK_PIX / 2; k++) begin
            e = pix[2*k];
            o = pix[2*k+1];
            h = o - (e >> 1);
            hs[k] = h;
            ls[k] = e + (h >> 2);
        end
        idx = 0; np = 0; cyc = 0;
        while (idx < BLK_PIX && cyc < 2000) begin
            in_valid = (np < BLK_PIX / 2);
            if (np < BLK_PIX / 2) begin in_L = ls[np]; in_H = hs[np]; end
            out_ready = ((cyc % 7) != 2);
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (out_pix !== pix[idx])
                    begin errors++; $display("FAIL rt_pix%0d got %0d want %0d", idx, out_pix, pix[idx]); end
`ifdef INV_LIFT_LAST_EN
                checks++;
                if (out_last !== (idx == BLK_PIX - 1))
                    begin errors++; $display("FAIL rt_last%0d got %b want %b", idx, out_last, (idx == BLK_PIX - 1)); end
`endif
                idx++;
            end
            if (in_valid && in_ready) np++;
            tick();
            cyc++;
        end
        checks++;
        if (idx != BLK_PIX) begin errors++; $display("FAIL rt_timeout got %0d pixels want %0d", idx, BLK_PIX); end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rt_extra got v=%b want 0", out_valid); end
    endtask

    task automatic test_wrap();
        out_ready = 1'b1; in_valid = 1'b1; in_L = 8'd0; in_H = 8'd4;
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_pix !== 8'd255)
            begin errors++; $display("FAIL wrap_even got v=%b pix=%0d want v=1 pix=255", out_valid, out_pix); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pix !== 8'd131)
            begin errors++; $display("FAIL wrap_odd got v=%b pix=%0d want v=1 pix=131", out_valid, out_pix); end
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_L = '0; in_H = '0; out_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_in_odd();
        test_round_trip();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inv_lift_decoder.md
INV_LIFT_DECODER -- requirements
Module: inv_lift_decoder

Interface
REQ-001 SHALL have parameter DW, default 8: coefficient and pixel width in bits.
REQ-002 SHALL have parameter BLK_PIX, default 64: pixels per block; a power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: a coefficient pair is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept a pair this cycle.
REQ-007 SHALL have port in_L, input, DW bits: low-band lifting coefficient.
REQ-008 SHALL have port in_H, input, DW bits: high-band lifting coefficient.
REQ-009 SHALL have port out_valid, output, 1 bit: out_pix holds a reconstructed pixel.
REQ-010 SHALL have port out_ready, input, 1 bit: the downstream accepts out_pix.
REQ-011 SHALL have port out_pix, output, DW bits: reconstructed pixel, even sample first, then odd.
REQ-012 SHALL have port out_last, output, 1 bit: marks the final pixel of a block; present only with INV_LIFT_LAST_EN.

Function
REQ-013 SHALL accept a pair only when in_valid and in_ready are both high in the same cycle.
REQ-014 SHALL compute even = in_L - (in_H >> 2) and odd = in_H + (even >> 1), using logical shifts and modulo 2^DW wrap, with no saturation.
REQ-015 SHALL register even and odd in the same edge on which the pair is accepted.
REQ-016 SHALL implement an FSM with states IDLE, EVEN and ODD.
REQ-017 SHALL go IDLE->EVEN on acceptance, EVEN->ODD on an out handshake, ODD->IDLE on an out handshake with no new pair, and ODD->EVEN on an out handshake with a simultaneous new pair.
REQ-018 SHALL drive in_ready = (state==IDLE) | (state==ODD & out_ready), combinationally, with no combinational path from in_valid.
REQ-019 SHALL drive out_valid high in EVEN and ODD and low in IDLE.
REQ-020 SHALL drive out_pix from the even register in EVEN and from the odd register in ODD.
REQ-021 SHALL hold out_pix stable while out_valid is high and out_ready is low.
REQ-022 SHALL present the first pixel (out_valid high) on the cycle after acceptance: latency 1.
REQ-023 SHALL sustain 2 pixels per pair with no bubble between consecutive pairs.
REQ-024 SHALL never drop or duplicate a pixel under any out_ready pattern.

Reset
REQ-025 SHALL, when rst_n is low at a clock edge, set state IDLE, out_valid 0, the even/odd registers 0, the pixel counter 0 and out_last 0.
REQ-026 SHALL discard any in-flight pair on reset mid-operation, with no pixel emitted.
REQ-027 SHALL hold in_ready at 0 on every cycle in which rst_n is low.

Configuration
REQ-028 SHALL, when INV_LIFT_LAST_EN is defined, include a log2(BLK_PIX)-bit pixel counter incremented on each out handshake and wrapping from BLK_PIX-1 to 0, plus the out_last port.
REQ-029 SHALL, with INV_LIFT_LAST_EN, drive out_last = out_valid & (counter == BLK_PIX-1).
REQ-030 SHALL, without INV_LIFT_LAST_EN, omit the counter and the out_last port, with all other behaviour identical.

Structure
REQ-031 SHALL take the FSM state enum (IDLE/EVEN/ODD), the shift constants SH_H=2 and SH_E=1, and the default DW/BLK_PIX from a shared package lift_pkg, which the forward lifting block also uses.
REQ-032 SHALL place the REQ-014 arithmetic in one combinational sub-module, inv_lift_core, with ports L, H, even and odd.

Verification
REQ-033 SHALL verify a single pair: L=205, H=240 -> pixels 145 then 56 on consecutive cycles, out_ready held 1.
REQ-034 SHALL verify back-to-back pairs: (205,240) then (65,65) -> 145, 56, 49, 89 with out_valid continuous and in_ready high on the ODD cycles.
REQ-035 SHALL verify backpressure: out_ready=0 for 3 cycles in EVEN -> out_pix held at 145, in_ready 0, then 145 and 56 emitted once each.
REQ-036 SHALL verify a round trip: 32 pairs produced by the forward transform of a 64-pixel block -> original 64 pixels in order, with out_last high only on pixel 63 (INV_LIFT_LAST_EN defined).
REQ-037 SHALL verify reset in ODD: rst_n=0 for 1 cycle -> out_valid 0 next cycle, odd pixel never emitted, counter restarts at 0.
REQ-038 SHALL verify wrap: L=0, H=4 -> even=255, odd=131 (mod 256).
